// File: rtl/matrix_mult_pkg.sv
// Shared types and row-major offset helpers for the sequential matrix multiplier.
// Optional build macro used elsewhere: MULT_M_SIGNED_EN.
package matrix_mult_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned RES_W  = 16;

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  function automatic int unsigned elem_off(input int unsigned i, input int unsigned j,
                                           input int unsigned ncol);
    return ELEM_W * (i * ncol + j);
  endfunction

  function automatic int unsigned res_off(input int unsigned i, input int unsigned j,
                                          input int unsigned ncol);
    return RES_W * (i * ncol + j);
  endfunction

endpackage

// File: rtl/matrix_multiplier_m_dot.sv
// Combinational dot product of one A row and one B column, truncated to RES_W bits.
// MULT_M_SIGNED_EN selects two's-complement operands; default is unsigned.
module mm_dot_product
  import matrix_mult_pkg::*;
#(
  parameter int unsigned dw  = 32,
  parameter int unsigned col = 4
) (
  input  logic [ELEM_W*col-1:0] row_vec,
  input  logic [ELEM_W*col-1:0] col_vec,
  output logic [RES_W-1:0]      dot
);

  logic [dw-1:0]    acc;
  logic [RES_W-1:0] ext_a;
  logic [RES_W-1:0] ext_b;
  logic [RES_W-1:0] prod;

  always_comb begin
    acc   = '0;
    ext_a = '0;
    ext_b = '0;
    prod  = '0;
    for (int unsigned k = 0; k < col; k++) begin
`ifdef MULT_M_SIGNED_EN
      ext_a = {{(RES_W-ELEM_W){row_vec[ELEM_W*k+ELEM_W-1]}}, row_vec[ELEM_W*k +: ELEM_W]};
      ext_b = {{(RES_W-ELEM_W){col_vec[ELEM_W*k+ELEM_W-1]}}, col_vec[ELEM_W*k +: ELEM_W]};
      prod  = ext_a * ext_b;
      acc   = acc + {{(dw-RES_W){prod[RES_W-1]}}, prod};
`else
      ext_a = {{(RES_W-ELEM_W){1'b0}}, row_vec[ELEM_W*k +: ELEM_W]};
      ext_b = {{(RES_W-ELEM_W){1'b0}}, col_vec[ELEM_W*k +: ELEM_W]};
      prod  = ext_a * ext_b;
      acc   = acc + {{(dw-RES_W){1'b0}}, prod};
`endif
    end
  end

  assign dot = acc[RES_W-1:0];

  // Upper accumulator bits only guard against internal overflow; the result wraps mod 2^16.
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[dw-1:RES_W];

endmodule

// File: rtl/matrix_multiplier_m.sv
// Sequential square-matrix multiplier: one result element per clock while busy_M is high.
// Signedness is chosen at build time by MULT_M_SIGNED_EN (undefined = unsigned).
module matrix_multiplier_m
  import matrix_mult_pkg::*;
#(
  parameter int unsigned dw  = 32,
  parameter int unsigned row = 4,
  parameter int unsigned col = 4
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       opcode,
  input  logic [ELEM_W*row*col-1:0]  in_A,
  input  logic [ELEM_W*row*col-1:0]  in_B,
  output logic [RES_W*row*col-1:0]   out_M,
  output logic                       busy_M
);

  localparam int unsigned NumElem = row * col;
  localparam int unsigned IdxW    = (NumElem > 1) ? $clog2(NumElem) : 1;

  state_e                        state_q, state_d;
  logic [IdxW-1:0]               idx_q;
  logic [ELEM_W*NumElem-1:0]     a_q, b_q;
  logic [RES_W*NumElem-1:0]      out_q;
  logic                          start, step, last;
  int unsigned                   cur_i, cur_j;
  logic [ELEM_W*col-1:0]         row_vec, col_vec;
  logic [RES_W-1:0]              dot;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    last    = (idx_q == IdxW'(NumElem - 1));
    unique case (state_q)
      IDLE: begin
        if (opcode) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Route row i of A and column j of B from the latched operands to the dot-product unit.
  always_comb begin
    cur_i   = 32'(idx_q) / col;
    cur_j   = 32'(idx_q) % col;
    row_vec = '0;
    col_vec = '0;
    for (int unsigned k = 0; k < col; k++) begin
      row_vec[ELEM_W*k +: ELEM_W] = a_q[elem_off(cur_i, k, col) +: ELEM_W];
      col_vec[ELEM_W*k +: ELEM_W] = b_q[elem_off(k, cur_j, col) +: ELEM_W];
    end
  end

  mm_dot_product #(
    .dw  (dw),
    .col (col)
  ) u_dot (
    .row_vec (row_vec),
    .col_vec (col_vec),
    .dot     (dot)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        a_q   <= in_A;
        b_q   <= in_B;
        out_q <= '0;
        idx_q <= '0;
      end else if (step) begin
        out_q[res_off(cur_i, cur_j, col) +: RES_W] <= dot;
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign out_M  = out_q;
  assign busy_M = (state_q == RUN);

endmodule

// File: tb/tb_matrix_multiplier_m.sv
// Directed self-checking bench for matrix_multiplier_m (4x4, 8-bit elements).
module tb_matrix_multiplier_m;

  logic         clk;
  logic         n_reset;
  logic         opcode;
  logic [127:0] in_A, in_B;
  logic [255:0] out_M;
  logic         busy_M;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_multiplier_m #(
    .dw  (32),
    .row (4),
    .col (4)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .opcode  (opcode),
    .in_A    (in_A),
    .in_B    (in_B),
    .out_M   (out_M),
    .busy_M  (busy_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain triple loop over element indices.
  function automatic logic [255:0] model(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] m;
    int acc;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef MULT_M_SIGNED_EN
          acc += int'($signed(a[8*(i*4+k) +: 8])) * int'($signed(b[8*(k*4+j) +: 8]));
`else
          acc += int'(a[8*(i*4+k) +: 8]) * int'(b[8*(k*4+j) +: 8]);
`endif
        end
        m[16*(i*4+j) +: 16] = acc[15:0];
      end
    end
    return m;
  endfunction

  function automatic logic [255:0] fill16(input logic [15:0] v);
    logic [255:0] m;
    for (int e = 0; e < 16; e++) m[16*e +: 16] = v;
    return m;
  endfunction

  // Pulse opcode across one rising edge; returns at the negedge right after the start edge.
  task automatic pulse_start;
    @(negedge clk) opcode = 1'b1;
    @(negedge clk) opcode = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy_M && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  int cyc;
  logic [127:0] a0, b0;
  logic [255:0] exp_m;

  initial begin
    n_reset = 1'b1;
    opcode  = 1'b0;
    in_A    = '0;
    in_B    = '0;

    // Asynchronous reset asserted mid-clock.
    #3 n_reset = 1'b0;
    #1;
    check("reset_out", out_M, '0);
    check("reset_busy", {255'b0, busy_M}, '0);
    #20 n_reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_out", out_M, '0);
    check("idle_busy", {255'b0, busy_M}, '0);

    // Uniform 0x0A operands.
    in_A = {16{8'h0A}};
    in_B = {16{8'h0A}};
    pulse_start();
    wait_done(cyc);
    check("uniform_busy_cycles", 256'(cyc), 256'd16);
    check("uniform_out", out_M, fill16(16'h0190));

    // Ramp operands.
    in_A = 128'h100f0e0d0c0b0a090807060504030201;
    in_B = 128'h0102030405060708090a0b0c0d0e0f10;
    pulse_start();
    wait_done(cyc);
    check("ramp_busy_cycles", 256'(cyc), 256'd16);
    check("ramp_c00", 256'(out_M[16*0 +: 16]), 256'h0050);
    check("ramp_c03", 256'(out_M[16*3 +: 16]), 256'h0032);
    check("ramp_c33", 256'(out_M[16*15 +: 16]), 256'h0182);
    check("ramp_all", out_M, model(in_A, in_B));

    // All 0xFF: wraps modulo 2^16.
    in_A = {16{8'hFF}};
    in_B = {16{8'hFF}};
    pulse_start();
    wait_done(cyc);
    check("ff_busy_cycles", 256'(cyc), 256'd16);
`ifdef MULT_M_SIGNED_EN
    check("ff_out", out_M, fill16(16'h0004));
`else
    check("ff_out", out_M, fill16(16'hF804));
`endif

    // Busy protection: retrigger and change operands while running.
    a0   = 128'h100f0e0d0c0b0a090807060504030201;
    b0   = 128'h0102030405060708090a0b0c0d0e0f10;
    in_A = a0;
    in_B = b0;
    pulse_start();
    check("start_clears_out", out_M, '0);
    cyc = 1;
    @(negedge clk);
    cyc++;
    opcode = 1'b1;
    in_A   = {16{8'h33}};
    in_B   = {16{8'h77}};
    @(negedge clk);
    cyc++;
    opcode = 1'b0;
    in_A   = '1;
    @(negedge clk);
    cyc++;
    begin
      int rest;
      wait_done(rest);
      cyc = cyc - 1 + rest;
    end
    check("busy_prot_cycles", 256'(cyc), 256'd16);
    check("busy_prot_out", out_M, model(a0, b0));
    exp_m = model(a0, b0);
    repeat (3) @(negedge clk);
    check("busy_prot_no_restart", {255'b0, busy_M}, '0);
    check("hold_after_done", out_M, exp_m);

    // Reset in the middle of a run, then a clean restart.
    in_A = {16{8'h0A}};
    in_B = {16{8'h0A}};
    pulse_start();
    repeat (7) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("midrun_reset_out", out_M, '0);
    check("midrun_reset_busy", {255'b0, busy_M}, '0);
    @(negedge clk) n_reset = 1'b1;
    repeat (2) @(negedge clk);
    check("after_reset_idle", {255'b0, busy_M}, '0);
    in_A = a0;
    in_B = b0;
    pulse_start();
    wait_done(cyc);
    check("restart_busy_cycles", 256'(cyc), 256'd16);
    check("restart_out", out_M, model(a0, b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
